alu_exec_unit: RTL and testbench

//  Multi-cycle integer ALU that consumes the 4-bit ALU control code produced by ALUDecoder.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_shifter.sv | 42 ++++
 rtl/alu_exec_unit.sv | 143 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control encodings (common with ALUDecoder), FSM state type and opcode helpers
// for alu_exec_unit.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SRA  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

  function automatic logic is_shift_op(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

  function automatic logic is_legal_op(input logic [3:0] ctrl);
    case (ctrl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SRA, ALU_SUB,
      ALU_SLT, ALU_SLL, ALU_SRL, ALU_XOR, ALU_SLTU: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Shift datapath for alu_exec_unit: a single-bit step per call in the serial build, or a full
// barrel shift when ALU_FAST_SHIFT_EN is defined.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] data,
`ifdef ALU_FAST_SHIFT_EN
  input  logic [SHW-1:0]  shamt,
`else
  input  logic            fill_msb,
`endif
  output logic [XLEN-1:0] shifted
);

`ifdef ALU_FAST_SHIFT_EN
  always_comb begin
    shifted = data;
    case (alu_ctrl)
      ALU_SLL: shifted = data << shamt;
      ALU_SRL: shifted = data >> shamt;
      ALU_SRA: shifted = $signed(data) >>> shamt;
      default: shifted = data;
    endcase
  end
`else
  // SRA takes its fill bit from the sign captured at accept, not from the evolving value.
  always_comb begin
    shifted = data;
    case (alu_ctrl)
      ALU_SLL: shifted = {data[XLEN-2:0], 1'b0};
      ALU_SRL: shifted = {1'b0, data[XLEN-1:1]};
      ALU_SRA: shifted = {fill_msb, data[XLEN-1:1]};
      default: shifted = data;
    endcase
  end
`endif

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage multi-cycle ALU with valid/ready handshakes on both sides. Shifts iterate one bit per
// cycle unless ALU_FAST_SHIFT_EN is defined, in which case every op completes in one cycle.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  alu_state_t      state, state_next;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] shift_out;
  logic            zero_q;
  logic            illegal_q;
  logic            accept;
  logic [SHW-1:0]  shamt;

  assign shamt  = op_b[SHW-1:0];
  assign accept = (state == ST_IDLE) && in_valid;

`ifdef ALU_FAST_SHIFT_EN
  alu_shifter #(.XLEN(XLEN), .SHW(SHW)) u_shifter (
    .alu_ctrl (alu_ctrl),
    .data     (op_a),
    .shamt    (shamt),
    .shifted  (shift_out)
  );
`else
  logic [3:0]     op_q;
  logic           sign_q;
  logic [SHW-1:0] count;

  // The serial shifter works in place on result_q, one step per SHIFT cycle.
  alu_shifter #(.XLEN(XLEN), .SHW(SHW)) u_shifter (
    .alu_ctrl (op_q),
    .data     (result_q),
    .fill_msb (sign_q),
    .shifted  (shift_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= ALU_AND;
      sign_q <= 1'b0;
      count  <= '0;
    end else if (accept) begin
      op_q   <= alu_ctrl;
      sign_q <= op_a[XLEN-1];
      count  <= shamt;
    end else if (state == ST_SHIFT) begin
      count  <= count - SHW'(1);
    end
  end
`endif

  // Value captured at accept; a serial shift starts from op_a and is refined in SHIFT.
  always_comb begin
    alu_out = op_a + op_b;
    case (alu_ctrl)
      ALU_AND:  alu_out = op_a & op_b;
      ALU_OR:   alu_out = op_a | op_b;
      ALU_XOR:  alu_out = op_a ^ op_b;
      ALU_ADD:  alu_out = op_a + op_b;
      ALU_SUB:  alu_out = op_a - op_b;
      ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, (op_a < op_b)};
`ifdef ALU_FAST_SHIFT_EN
      ALU_SLL, ALU_SRL, ALU_SRA: alu_out = shift_out;
`else
      ALU_SLL, ALU_SRL, ALU_SRA: alu_out = op_a;
`endif
      default:  alu_out = op_a + op_b;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef ALU_FAST_SHIFT_EN
          state_next = ST_DONE;
`else
          state_next = (is_shift_op(alu_ctrl) && (shamt != '0)) ? ST_SHIFT : ST_DONE;
`endif
        end
      end
      ST_SHIFT: begin
`ifdef ALU_FAST_SHIFT_EN
        state_next = ST_DONE;
`else
        if (count == SHW'(1)) state_next = ST_DONE;
`endif
      end
      ST_DONE:  if (out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        result_q  <= alu_out;
        zero_q    <= (alu_out == '0);
        illegal_q <= !is_legal_op(alu_ctrl);
      end
`ifndef ALU_FAST_SHIFT_EN
      else if (state == ST_SHIFT) begin
        result_q <= shift_out;
        zero_q   <= (shift_out == '0);
      end
`endif
    end
  end

  assign in_ready  = (state == ST_IDLE) && !reset;
  assign out_valid = (state == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, backpressure and reset
// sequences, then randomized ops against a behavioural model.
module tb_alu_exec_unit;

  localparam int XLEN = 32;
`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctrl = 4'b0000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_compared = 0;
  int n_mismatch = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          lat;
  } vec_t;

  function automatic logic is_shift(input logic [3:0] c);
    return (c == 4'b1000) || (c == 4'b1001) || (c == 4'b0011);
  endfunction

  // Reference behaviour from the op definitions, in plain arithmetic.
  function automatic logic [31:0] model_result(input logic [3:0] c, input logic [31:0] a,
                                               input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return $signed(a) >>> sh;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: return a << sh;
      4'b1001: return a >> sh;
      4'b1010: return a ^ b;
      4'b1111: return (a < b) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  function automatic logic model_illegal(input logic [3:0] c);
    return !(c inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110,
                       4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1111});
  endfunction

  function automatic int model_latency(input logic [3:0] c, input logic [31:0] b);
    if (!FAST && is_shift(c) && (b[4:0] != 5'd0)) return 1 + int'(b[4:0]);
    return 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issues one op, measures cycles from the accept cycle to out_valid, then acknowledges it.
  task automatic applyStimulus(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] res, output logic z, output logic ill,
                               output int lat);
    int waited;
    waited = 0;
    lat = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) checkOutput("accept_timeout", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_ctrl = 4'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    res = result;
    z   = zero;
    ill = illegal;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  vec_t        vecs[13];
  logic [31:0] got_res;
  logic        got_z;
  logic        got_ill;
  int          got_lat;

  initial begin
    vecs[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1};
    vecs[1]  = '{4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1};
    vecs[2]  = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1};
    vecs[3]  = '{4'b1111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1};
    vecs[4]  = '{4'b0011, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0, 5};
    vecs[5]  = '{4'b1000, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0, 1};
    vecs[6]  = '{4'b0100, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, 1'b1, 1};
    vecs[7]  = '{4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1};
    vecs[8]  = '{4'b0001, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1'b0, 1};
    vecs[9]  = '{4'b1010, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0000_0000, 1'b1, 1'b0, 1};
    vecs[10] = '{4'b1001, 32'h8000_0001, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0, 32};
    vecs[11] = '{4'b1000, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0, 32};
    vecs[12] = '{4'b0011, 32'h4000_0000, 32'h0000_0021, 32'h2000_0000, 1'b0, 1'b0, 2};

    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_zero", {31'b0, zero}, 32'd1);
    checkOutput("rst_illegal", {31'b0, illegal}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("idle_in_ready", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].ctrl, vecs[i].a, vecs[i].b, got_res, got_z, got_ill, got_lat);
      checkOutput($sformatf("vec%0d_result", i), got_res, vecs[i].res);
      checkOutput($sformatf("vec%0d_zero", i), {31'b0, got_z}, {31'b0, vecs[i].z});
      checkOutput($sformatf("vec%0d_illegal", i), {31'b0, got_ill}, {31'b0, vecs[i].ill});
      checkOutput($sformatf("vec%0d_latency", i), got_lat, FAST ? 32'd1 : vecs[i].lat);
    end

    // Backpressure: result held, new requests ignored until the consumer accepts.
    @(negedge clk);
    in_valid = 1'b1;
    alu_ctrl = 4'b0010;
    op_a = 32'd1;
    op_b = 32'd2;
    @(posedge clk);
    #1;
    alu_ctrl = 4'b0110;
    op_a = 32'd9;
    op_b = 32'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("bp_result", result, 32'd3);
      checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("bp_ignored_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("bp_ignored_result", result, 32'd3);

    // Reset in the middle of a long shift.
    @(negedge clk);
    in_valid = 1'b1;
    alu_ctrl = 4'b1001;
    op_a = 32'hFFFF_FFFF;
    op_b = 32'd31;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midrst_result", result, 32'd0);
    checkOutput("midrst_zero", {31'b0, zero}, 32'd1);
    checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(4'b0010, 32'd10, 32'd20, got_res, got_z, got_ill, got_lat);
    checkOutput("postrst_result", got_res, 32'd30);
    checkOutput("postrst_latency", got_lat, 32'd1);

    // Randomized ops against the behavioural model.
    for (int i = 0; i < 200; i++) begin
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if (($urandom % 4) == 0) b = a;
      exp_res = model_result(c, a, b);
      applyStimulus(c, a, b, got_res, got_z, got_ill, got_lat);
      checkOutput($sformatf("rnd%0d_result", i), got_res, exp_res);
      checkOutput($sformatf("rnd%0d_zero", i), {31'b0, got_z}, {31'b0, exp_res == 32'd0});
      checkOutput($sformatf("rnd%0d_illegal", i), {31'b0, got_ill}, {31'b0, model_illegal(c)});
      checkOutput($sformatf("rnd%0d_latency", i), got_lat, model_latency(c, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
